// File: rtl/matrix_result_streamer.sv
// Drains a ROWS x COLS result RAM (1-cycle read latency) onto a valid/ready stream,
// row- or column-major per run. Optional checksum port under RESULT_CHECKSUM_EN.
module matrix_result_streamer #(
  parameter int unsigned  ROWS   = 8,
  parameter int unsigned  COLS   = 8,
  parameter int unsigned  DATA_W = 32,
  localparam int unsigned ROW_W  = $clog2(ROWS) + 1,
  localparam int unsigned COL_W  = $clog2(COLS) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              col_major,
  output logic              rd_en,
  output logic [ROW_W-1:0]  rd_row,
  output logic [COL_W-1:0]  rd_col,
  input  logic [DATA_W-1:0] rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  output logic              done
`ifdef RESULT_CHECKSUM_EN
  ,
  output logic [31:0]       checksum
`endif
);

  typedef enum logic [1:0] {StIdle, StRun, StFlush, StDone} state_e;

  state_e            state_q, state_d;
  logic [ROW_W-1:0]  row_q;
  logic [COL_W-1:0]  col_q;
  logic              mode_q;
  logic              inflight_q, inflight_last_q;
  logic [DATA_W-1:0] fifo_data_q [2];
  logic [1:0]        fifo_last_q;
  logic              wr_ptr_q, rd_ptr_q;
  logic [1:0]        count_q;

  logic              fifo_empty, pop, bypass, fifo_push, fifo_pop;
  logic              row_end, col_end, rd_is_last, start_accept;
  logic [2:0]        occupancy;
  logic [DATA_W-1:0] head_data;
  logic              head_last;

  // Read data in flight is presented directly when the FIFO is empty, so the
  // first element appears in the same cycle the RAM returns it.
  always_comb begin
    fifo_empty   = (count_q == 2'd0);
    out_valid    = ~fifo_empty | inflight_q;
    head_data    = fifo_empty ? rd_data : fifo_data_q[rd_ptr_q];
    head_last    = fifo_empty ? inflight_last_q : fifo_last_q[rd_ptr_q];
    out_data     = out_valid ? head_data : '0;
    out_last     = out_valid & head_last;
    pop          = out_valid & out_ready;
    bypass       = fifo_empty & inflight_q & pop;
    fifo_push    = inflight_q & ~bypass;
    fifo_pop     = pop & ~fifo_empty;
    occupancy    = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
    row_end      = (row_q == ROW_W'(ROWS - 1));
    col_end      = (col_q == COL_W'(COLS - 1));
    rd_is_last   = row_end & col_end;
    rd_en        = (state_q == StRun) && (occupancy < 3'd2);
    rd_row       = rd_en ? row_q : '0;
    rd_col       = rd_en ? col_q : '0;
    start_accept = (state_q == StIdle) & start;
    busy         = (state_q != StIdle);
  end

  always_comb begin
    state_d = state_q;
    done    = 1'b0;
    unique case (state_q)
      StIdle:  if (start) state_d = StRun;
      StRun:   if (rd_en && rd_is_last) state_d = StFlush;
      StFlush: if (pop && head_last) state_d = StDone;
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Both walk orders end on (ROWS-1, COLS-1), which marks the final read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_q  <= '0;
      col_q  <= '0;
      mode_q <= 1'b0;
    end else if (start_accept) begin
      row_q  <= '0;
      col_q  <= '0;
      mode_q <= col_major;
    end else if (rd_en) begin
      if (!mode_q) begin
        if (col_end) begin
          col_q <= '0;
          row_q <= row_q + ROW_W'(1);
        end else begin
          col_q <= col_q + COL_W'(1);
        end
      end else begin
        if (row_end) begin
          row_q <= '0;
          col_q <= col_q + COL_W'(1);
        end else begin
          row_q <= row_q + ROW_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
    end else begin
      inflight_q      <= rd_en;
      inflight_last_q <= rd_en & rd_is_last;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_data_q[0] <= '0;
      fifo_data_q[1] <= '0;
      fifo_last_q    <= '0;
      wr_ptr_q       <= 1'b0;
      rd_ptr_q       <= 1'b0;
      count_q        <= '0;
    end else begin
      if (fifo_push) begin
        fifo_data_q[wr_ptr_q] <= rd_data;
        fifo_last_q[wr_ptr_q] <= inflight_last_q;
        wr_ptr_q              <= ~wr_ptr_q;
      end
      if (fifo_pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_q + {1'b0, fifo_push} - {1'b0, fifo_pop};
    end
  end

`ifdef RESULT_CHECKSUM_EN
  logic [31:0] data32, checksum_q;

  if (DATA_W >= 32) begin : g_trunc
    assign data32 = out_data[31:0];
  end else begin : g_ext
    assign data32 = {{(32 - DATA_W){1'b0}}, out_data};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      checksum_q <= '0;
    end else if (start_accept) begin
      checksum_q <= '0;
    end else if (pop) begin
      checksum_q <= checksum_q + data32;
    end
  end

  assign checksum = checksum_q;
`endif

endmodule
